// File: rtl/spi_shift_engine.sv
// spi_shift_engine: full-duplex SPI master shift engine.
// All CPOL/CPHA modes, selectable bit order, registered pins.
module spi_shift_engine #(
  parameter int DATA_W    = 8,
  parameter int DIV_W     = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic              CLK,
  input  logic              CLR_N,
  input  logic [DATA_W-1:0] TX_DATA,
  input  logic              TX_VALID,
  output logic              TX_READY,
  input  logic              CPOL,
  input  logic              CPHA,
  input  logic [DIV_W-1:0]  DIV,
  output logic [DATA_W-1:0] RX_DATA,
  output logic              RX_VALID,
  output logic              BUSY,
  output logic              SCLK,
  output logic              MOSI,
  input  logic              MISO,
  output logic              CS_N
);

  localparam int IW = $clog2(DATA_W);
  localparam int EW = $clog2(2*DATA_W+1);
  localparam logic [EW-1:0] LAST = EW'(2*DATA_W);

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    XFER,
    TRAIL,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [EW-1:0]     edge_q, edge_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
  logic              cpol_q, cpol_d;
  logic              cpha_q, cpha_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic              cs_n_q, cs_n_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              tick;
  logic              do_edge;
  logic [IW-1:0]     samp_i;
  logic [IW-1:0]     drv_i;

  function automatic logic [IW-1:0] pos(
    input logic [IW-1:0] i
  );
    pos = LSB_FIRST ? i : IW'(DATA_W-1) - i;
  endfunction

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    edge_d     = edge_q;
    tx_d       = tx_q;
    rx_sh_d    = rx_sh_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    div_d      = div_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    cs_n_d     = cs_n_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    do_edge    = 1'b0;
    tick       = (cnt_q == div_q);
    unique case (state_q)
      IDLE: begin
        sclk_d = CPOL;
        cs_n_d = 1'b1;
        if (TX_VALID && ready_q) begin
          state_d = LEAD;
          tx_d    = TX_DATA;
          cpol_d  = CPOL;
          cpha_d  = CPHA;
          div_d   = DIV;
          cnt_d   = '0;
          edge_d  = '0;
          rx_sh_d = '0;
          cs_n_d  = 1'b0;
          if (!CPHA) mosi_d = TX_DATA[pos('0)];
        end
      end
      LEAD: begin
        cnt_d = tick ? '0 : cnt_q + 1'b1;
        if (tick) begin
          state_d = XFER;
          do_edge = 1'b1;
        end
      end
      XFER: begin
        cnt_d = tick ? '0 : cnt_q + 1'b1;
        if (tick) begin
          if (edge_q == LAST) state_d = TRAIL;
          else do_edge = 1'b1;
        end
      end
      TRAIL: begin
        cnt_d = tick ? '0 : cnt_q + 1'b1;
        if (tick) begin
          state_d    = DONE;
          cs_n_d     = 1'b1;
          rx_data_d  = rx_sh_q;
          rx_valid_d = 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (do_edge) begin
      edge_d = edge_q + 1'b1;
      sclk_d = ~sclk_q;
    end
    samp_i = IW'((edge_d - 1'b1) >> 1);
    drv_i  = IW'(edge_d >> 1);
    // odd edges lead; sample on lead when CPHA=0, on trail when CPHA=1
    if (do_edge) begin
      if (edge_d[0] ^ cpha_q) rx_sh_d[pos(samp_i)] = MISO;
      else if (cpha_q) mosi_d = tx_q[pos(samp_i)];
      else if (edge_d != LAST) mosi_d = tx_q[pos(drv_i)];
    end

    ready_d = (state_d == IDLE);
    busy_d  = state_d inside {LEAD, XFER, TRAIL};
  end

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      edge_q     <= '0;
      tx_q       <= '0;
      rx_sh_q    <= '0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      div_q      <= '0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      edge_q     <= edge_d;
      tx_q       <= tx_d;
      rx_sh_q    <= rx_sh_d;
      cpol_q     <= cpol_d;
      cpha_q     <= cpha_d;
      div_q      <= div_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      cs_n_q     <= cs_n_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
    end
  end

  assign TX_READY = ready_q;
  assign BUSY     = busy_q;
  assign RX_DATA  = rx_data_q;
  assign RX_VALID = rx_valid_q;
  assign SCLK     = sclk_q;
  assign MOSI     = mosi_q;
  assign CS_N     = cs_n_q;

endmodule

// File: doc/spi_shift_engine.md
Name: spi_shift_engine

Overview:
- Parametrised full-duplex SPI transfer engine. It is the single-clock successor of the separate 8-bit sender/receiver pair.
- One block serialises TX words onto MOSI, deserialises MISO into RX words, generates SCLK and CS_N, and supports all four CPOL/CPHA modes plus selectable bit order.
- It sits between the host-side word interface (valid/ready) and the SPI pins, and replaces the TE/RE/WRITE/READ strobe scheme with a handshake.

Parameters:
- DATA_W, 8, bits per transfer (2..32).
- DIV_W, 8, width of the SCLK divider input.
- LSB_FIRST, 1, 1 = bit 0 shifted first (legacy order), 0 = MSB first.

Ports:
- CLK  in  1  system clock, all logic on rising edge.
- CLR_N  in  1  asynchronous active-low reset.
- TX_DATA  in  DATA_W  word to transmit.
- TX_VALID  in  1  host offers TX_DATA.
- TX_READY  out  1  engine can accept a word (IDLE only).
- CPOL  in  1  SCLK idle level.
- CPHA  in  1  0 = sample on leading edge, 1 = sample on trailing edge.
- DIV  in  DIV_W  SCLK half-period = DIV+1 CLK cycles.
- RX_DATA  out  DATA_W  last received word.
- RX_VALID  out  1  one-cycle pulse, RX_DATA updated.
- BUSY  out  1  high from accept until return to IDLE.
- SCLK  out  1  SPI clock.
- MOSI  out  1  serial out.
- MISO  in  1  serial in.
- CS_N  out  1  active-low chip select.

Behaviour:
- Reset (CLR_N=0, async, overrides everything):
  - SCLK=0, MOSI=0, CS_N=1, TX_READY=0, BUSY=0, RX_VALID=0, RX_DATA=0.
  - FSM goes to IDLE. First cycle after release: TX_READY=1.
- Reset mid-transfer aborts immediately: CS_N rises asynchronously, no RX_VALID, and the partial word is discarded.
- All SPI pins are registered, so there are no combinational paths from inputs to pins.
- Accept: TX_VALID & TX_READY on a rising edge. On accept, the engine latches TX_DATA, CPOL, CPHA and DIV; later changes to these inputs are ignored until the next accept.
- While not in IDLE, TX_READY=0 and TX_VALID is ignored.
- FSM states are IDLE -> LEAD -> XFER -> TRAIL -> DONE -> IDLE. Let H = DIV+1.
  - IDLE: CS_N=1, SCLK=CPOL (live input), TX_READY=1, BUSY=0.
  - LEAD: entered the cycle after accept; lasts H cycles.
    - CS_N=0, SCLK=CPOL_latched.
    - If CPHA=0, MOSI = first bit from the start of LEAD.
  - XFER: 2*DATA_W SCLK edges, one every H cycles, so the state lasts 2*DATA_W*H cycles. The first edge is the leading edge (away from CPOL).
    - CPHA=0: sample MISO on leading edges; shift and drive the next MOSI bit on trailing edges (no MOSI update after the final edge).
    - CPHA=1: drive MOSI on leading edges (first bit on edge 1); sample MISO on trailing edges.
    - Edge and bit counters wrap-free: the bit counter runs 0..DATA_W-1, and XFER exits after edge 2*DATA_W.
  - TRAIL: lasts H cycles; CS_N=0, SCLK=CPOL_latched.
  - DONE: lasts 1 cycle.
    - CS_N=1, RX_DATA <= assembled word, RX_VALID=1, BUSY=0.
    - The next state is IDLE, where TX_READY=1, so the minimum CS_N high time between words is 2 cycles.
- Received bits are placed in the same bit order as transmitted: with LSB_FIRST=1, the first sampled bit goes to RX_DATA[0].
- DIV=0 gives the fastest operation, with SCLK = CLK/2. DIV is treated as unsigned; DIV = all-ones is legal (H = 2^DIV_W).
- Back-to-back: if TX_VALID is held, the next accept happens on the first IDLE cycle after DONE.
- RX_DATA holds its value until the next DONE.
- MOSI holds its last value in IDLE; no tri-state.

Test Plan:
- Reset mid-transfer: CLR_N low at edge 5 of a transfer -> CS_N=1 within the same cycle, no RX_VALID pulse, TX_READY=1 on the first cycle after release.
- Mode 0 loopback (MOSI tied to MISO), DATA_W=8, LSB_FIRST=1, DIV=0, TX_DATA=0xA5:
  - MOSI bit order 1,0,1,0,0,1,0,1.
  - CS_N low for exactly 18 cycles.
  - RX_VALID pulses once with RX_DATA=0xA5.
- Mode 3 (CPOL=1, CPHA=1), DIV=3, LSB_FIRST=0, MISO driven from a model slave returning 0x3C for TX_DATA=0xC3:
  - SCLK idles high with half-period 4 cycles.
  - MOSI shows 1,1,0,0,0,0,1,1 (MSB first).
  - RX_DATA=0x3C.
- Back-to-back with TX_VALID held high, words 0x01 and 0xFE:
  - Two transfers occur, with CS_N high for exactly 2 cycles between them.
  - RX_VALID pulses twice.
  - TX_READY is low throughout each transfer.
- Latch check: change CPOL, CPHA, DIV and TX_DATA one cycle after accept -> the waveform matches the values at accept; the new CPOL is visible on SCLK only in IDLE.
